// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: FSM state and bus transfer-size encodings shared by the bridge
package data_sram_bridge_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/data_sram_bridge_size_decode.sv
// sram_size_decode: maps MEM-stage byte write enables onto bus direction and transfer size
module sram_size_decode
    import data_sram_bridge_pkg::*;
(
    input  logic [3:0] wea,
    output logic       wr,
    output logic [1:0] size
);
    logic one_hot;
    // any enable bit makes a write; irregular masks fall back to a word write
    always_comb begin
        one_hot = (wea != 4'b0000) && ((wea & (wea - 4'd1)) == 4'b0000);
        wr = |wea;
        size = one_hot ? SIZE_BYTE : (wea == 4'b0011 || wea == 4'b1100) ? SIZE_HALF : SIZE_WORD;
    end
endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns single-cycle MEM-stage accesses into handshaked SRAM-like bus transactions
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wea,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);
    state_t            state;
    logic              dec_wr;
    logic [1:0]        dec_size;
    logic [DATA_W-1:0] rdata_q;

    sram_size_decode u_dec (
        .wea  (cpu_wea),
        .wr   (dec_wr),
        .size (dec_size)
    );

    assign cpu_rdata = rdata_q;
    assign mem_stall = (state == IDLE) ? cpu_en : (state != DONE);

    // request registers drive the bus directly; DONE always returns to IDLE so nothing is re-issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_en) begin
                    state      <= REQ;
                    data_req   <= 1'b1;
                    data_wr    <= dec_wr;
                    data_size  <= dec_size;
                    data_addr  <= cpu_addr;
                    data_wdata <= cpu_wdata;
                end
                REQ: if (data_addr_ok) begin
                    state    <= WAIT;
                    data_req <= 1'b0;
                end
                WAIT: if (data_data_ok) begin
                    state   <= DONE;
                    rdata_q <= data_wr ? rdata_q : data_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
